vec_mem_seq: RTL and testbench
==============================

Name: vec_mem_seq

Overview:
Vector load/store sequencer between the CVP14 control core and the DRAM port. On a start pulse it streams the VEC_LEN elements of one vector register to or from DRAM, one element per transfer. It drives the DRAM Addr/RD/WR/DataOut and captures DataIn for loads. It returns element writes to the vector register file and signals done to the core's state machine.

Parameters:
VEC_LEN, 16, elements per vector register
DW, 16, element and DRAM data width
AW, 16, DRAM address width
RD_LAT, 1, cycles from RD asserted to valid DataIn (1..3)

Ports:
Clk1  in  1  sole clock; all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  one-cycle request; sampled only in IDLE
IsStore  in  1  1 = store (vector to DRAM), 0 = load (DRAM to vector)
BaseAddr  in  AW  address of element 0, latched on Start
Stride  in  AW  element address increment (present only with VMS_STRIDE_EN)
VecRdData  in  DW  vector register element selected by ElemIdx (combinational read)
DataIn  in  DW  DRAM read data
Addr  out  AW  DRAM address
RD  out  1  DRAM read strobe
WR  out  1  DRAM write strobe
DataOut  out  DW  DRAM write data
ElemIdx  out  log2(VEC_LEN)  element index for the vector register file
VecWrEn  out  1  vector element write strobe (loads)
VecWrData  out  DW  loaded element
Busy  out  1  high from the cycle after Start until Done
Done  out  1  one-cycle pulse when the transfer is complete

Behaviour:
- Reset values: Addr=0, RD=0, WR=0, DataOut=0, ElemIdx=0, VecWrEn=0, VecWrData=0, Busy=0, Done=0, state=IDLE. Reset mid-transfer aborts immediately; no Done is produced.
- States:
  - IDLE
  - ST_ISSUE: store; one element per cycle
  - LD_ISSUE: load; one RD per cycle
  - LD_DRAIN: wait for outstanding loads to return
  - FINISH
- IDLE: on Start, latch BaseAddr into the address counter, clear the element counter, and set Busy=1. Go to ST_ISSUE if IsStore=1, otherwise LD_ISSUE. Start while Busy is ignored.
- ST_ISSUE: each cycle drive WR=1, Addr=addr counter, DataOut=VecRdData, ElemIdx=element counter. Then advance the counter by the stride. After element VEC_LEN-1, go to FINISH. This is exactly VEC_LEN WR cycles, back to back.
- LD_ISSUE: each cycle drive RD=1, Addr=addr counter, and push the element index into an RD_LAT-deep delay pipe. After the last issue, go to LD_DRAIN.
- Load return: when an index exits the delay pipe, drive VecWrEn=1, ElemIdx=that index, VecWrData=DataIn in the same cycle. During LD_ISSUE, ElemIdx follows the returning index, not the issue index.
- LD_DRAIN: stays RD_LAT cycles until the final VecWrEn, then goes to FINISH.
- FINISH: Done=1 and Busy=0 for one cycle, then IDLE.
- Latency, start to Done:
  - store: VEC_LEN+1 cycles
  - load: VEC_LEN+RD_LAT+1 cycles
  - with VEC_LEN=16, RD_LAT=1: store 17, load 18
- RD and WR are never high together. Addr holds its last value when idle, with RD=WR=0.
- Address arithmetic is modulo 2^AW; an address past 16'hFFFF wraps to 16'h0000 silently.
- Start coincident with Done (FINISH cycle) is ignored; the core must re-issue it in IDLE.

Optional Feature:
VMS_STRIDE_EN
- Defined: the Stride port exists and is latched on Start; the address increments by the latched Stride, modulo 2^AW. Stride=0 makes every transfer hit BaseAddr: a load broadcasts one word to all elements, a store writes VEC_LEN times to one word, and the last element wins.
- Undefined: the Stride port is absent and the increment is the constant 1.

Decomposition:
- Shared package cvp14_pkg holds:
  - VEC_LEN, DW, AW
  - the vms_state_t enum (IDLE, ST_ISSUE, LD_ISSUE, LD_DRAIN, FINISH)
  - the element-index width localparam
- One sub-module: vms_idx_pipe, an RD_LAT-stage valid+index shift register that produces VecWrEn and ElemIdx for returning loads.

Test Plan:
- Reset mid-load: assert Reset_n low at element 5 of a load. All outputs return to reset values asynchronously; no Done; the next Start works normally.
- Load, BaseAddr=16'h0040, DRAM[0x40+i]=16'hA000+i: exactly 16 RD cycles, then VecWrEn with ElemIdx 0..15 carrying A000..A00F. Done at cycle 18.
- Store, VecRdData=16'h5500+ElemIdx, BaseAddr=16'h0100: 16 WR cycles at Addr 0100..010F with data 5500..550F, no RD. Done at cycle 17; DRAM dump matches.
- Wrap, BaseAddr=16'hFFFC: Addr sequence FFFC, FFFD, FFFE, FFFF, 0000 .. 000B.
- Start pulsed while Busy, and Start on the Done cycle: both ignored, no extra transfers; RD and WR never high simultaneously, checked every cycle.
- VMS_STRIDE_EN, Stride=4, BaseAddr=0: Addr 0, 4, .. 3C. Stride=0 load with DRAM[0]=16'hBEEF: all 16 elements = BEEF.

Source files
------------

// File: rtl/vec_mem_seq_pkg.sv
// rtl/vec_mem_seq_pkg.sv - shared CVP14 vector memory sequencer constants and types
// Contents: VEC_LEN/DW/AW sizing, element-index width, sequencer state enum.
package cvp14_pkg;

    localparam int VEC_LEN = 16;
    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int IDX_W   = $clog2(VEC_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_ISSUE = 3'd1,
        LD_ISSUE = 3'd2,
        LD_DRAIN = 3'd3,
        FINISH   = 3'd4
    } vms_state_t;

endpackage

// File: rtl/vec_mem_seq_if.sv
// rtl/vec_mem_seq_if.sv - core/DRAM/vector-file bus of the vector memory sequencer
// Signals: Start/IsStore/BaseAddr[/Stride] request, VecRdData/DataIn read data,
//          Addr/RD/WR/DataOut DRAM side, ElemIdx/VecWrEn/VecWrData vector file side,
//          Busy/Done status. Stride exists only when VMS_STRIDE_EN is defined.
// Modports: slave = sequencer, master = core/DRAM/vector file environment.
interface vms_if;
    import cvp14_pkg::*;

    logic             Start;
    logic             IsStore;
    logic [AW-1:0]    BaseAddr;
`ifdef VMS_STRIDE_EN
    logic [AW-1:0]    Stride;
`endif
    logic [DW-1:0]    VecRdData;
    logic [DW-1:0]    DataIn;
    logic [AW-1:0]    Addr;
    logic             RD;
    logic             WR;
    logic [DW-1:0]    DataOut;
    logic [IDX_W-1:0] ElemIdx;
    logic             VecWrEn;
    logic [DW-1:0]    VecWrData;
    logic             Busy;
    logic             Done;

    modport slave (
`ifdef VMS_STRIDE_EN
        input  Stride,
`endif
        input  Start, IsStore, BaseAddr, VecRdData, DataIn,
        output Addr, RD, WR, DataOut, ElemIdx, VecWrEn, VecWrData, Busy, Done
    );

    modport master (
`ifdef VMS_STRIDE_EN
        output Stride,
`endif
        output Start, IsStore, BaseAddr, VecRdData, DataIn,
        input  Addr, RD, WR, DataOut, ElemIdx, VecWrEn, VecWrData, Busy, Done
    );

endinterface

// File: rtl/vec_mem_seq_idx_pipe.sv
// rtl/vec_mem_seq_idx_pipe.sv - RD_LAT-stage valid+index delay line for returning loads
// Ports: clk_i, rst_ni (async active-low), push_i/idx_i issue side,
//        valid_o/idx_o return side (aligned with DRAM DataIn).
module vms_idx_pipe
    import cvp14_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [IDX_W-1:0]  idx_q [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
        end else begin
            valid_q[0] <= push_i;
            idx_q[0]   <= idx_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign idx_o   = idx_q[RD_LAT-1];

endmodule

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - CVP14 vector load/store sequencer between vector file and DRAM
// Ports: Clk1, Reset_n (async active-low), bus (vms_if.slave, see vec_mem_seq_if.sv).
// Parameter RD_LAT (1..3): DRAM read latency in cycles.
// Optional: VMS_STRIDE_EN adds a latched Stride; otherwise the address step is 1.
module vec_mem_seq #(
    parameter int RD_LAT = 1
) (
    input  logic Clk1,
    input  logic Reset_n,
    vms_if.slave bus
);
    import cvp14_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    vms_state_t       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_addr_q, last_addr_d;
    logic [AW-1:0]    step;
    logic [IDX_W-1:0] elem_q, elem_d;
    logic [IDX_W-1:0] ret_idx;
    logic             ret_valid;
    logic             issuing;
    logic             loading;

`ifdef VMS_STRIDE_EN
    logic [AW-1:0]    stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    assign issuing = (state_q == ST_ISSUE) || (state_q == LD_ISSUE);
    assign loading = (state_q == LD_ISSUE) || (state_q == LD_DRAIN);

    vms_idx_pipe #(.RD_LAT(RD_LAT)) u_idx_pipe (
        .clk_i   (Clk1),
        .rst_ni  (Reset_n),
        .push_i  (state_q == LD_ISSUE),
        .idx_i   (elem_q),
        .valid_o (ret_valid),
        .idx_o   (ret_idx)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        elem_d      = elem_q;
`ifdef VMS_STRIDE_EN
        stride_d    = stride_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    addr_d   = bus.BaseAddr;
                    elem_d   = '0;
`ifdef VMS_STRIDE_EN
                    stride_d = bus.Stride;
`endif
                    state_d  = bus.IsStore ? ST_ISSUE : LD_ISSUE;
                end
            end
            ST_ISSUE, LD_ISSUE: begin
                // Remember the issued address so Addr can hold it once idle.
                last_addr_d = addr_q;
                addr_d      = addr_q + step;
                elem_d      = elem_q + IDX_W'(1);
                if (elem_q == LAST_IDX)
                    state_d = (state_q == ST_ISSUE) ? FINISH : LD_DRAIN;
            end
            LD_DRAIN: begin
                if (ret_valid && (ret_idx == LAST_IDX)) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            elem_q      <= '0;
`ifdef VMS_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            elem_q      <= elem_d;
`ifdef VMS_STRIDE_EN
            stride_q    <= stride_d;
`endif
        end
    end

    always_comb begin
        bus.WR        = (state_q == ST_ISSUE);
        bus.RD        = (state_q == LD_ISSUE);
        bus.Addr      = issuing ? addr_q : last_addr_q;
        bus.DataOut   = bus.WR ? bus.VecRdData : '0;
        // While loading, the vector file index belongs to the returning element.
        bus.ElemIdx   = loading ? ret_idx : elem_q;
        bus.VecWrEn   = loading && ret_valid;
        bus.VecWrData = bus.VecWrEn ? bus.DataIn : '0;
        bus.Busy      = issuing || (state_q == LD_DRAIN);
        bus.Done      = (state_q == FINISH);
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - self-checking bench for vec_mem_seq (table vectors plus reset/ignore sequences)
module tb_vec_mem_seq;
    import cvp14_pkg::*;

    logic Clk1 = 1'b0;
    logic Reset_n;
    vms_if bus();

    vec_mem_seq #(.RD_LAT(1)) dut (
        .Clk1    (Clk1),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk1 = ~Clk1;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] vreg [VEC_LEN];
    logic [DW-1:0] exp_mem [logic [15:0]];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] vrd_base;
    int            done_cnt = 0;
    int            both_cnt = 0;

    assign bus.VecRdData = vrd_base + DW'(bus.ElemIdx);

    // DRAM with one-cycle read latency, vector register file, event counters.
    always @(posedge Clk1) begin
        if (bus.RD) bus.DataIn <= mem[bus.Addr];
        if (bus.WR) mem[bus.Addr] <= bus.DataOut;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.VecWrEn) vreg[bus.ElemIdx] <= bus.VecWrData;
        if (bus.Done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.RD === 1'b1 && bus.WR === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {7'd0, bus.Addr, bus.RD, bus.WR, bus.DataOut, bus.ElemIdx,
                bus.VecWrEn, bus.VecWrData, bus.Busy, bus.Done};
    endfunction

    typedef struct {
        logic        is_store;
        logic [15:0] base;
        logic [15:0] stride;
        logic [15:0] pat;
        logic [15:0] pstep;
        logic        poke;
        int          lat;
    } vec_t;

    vec_t tab [8];
    int   ntab;

    task automatic run_vec(input vec_t v);
        int cyc, wr_n, rd_n, ld_n, addr_bad, data_bad, busy_bad, act, mis;
        logic [15:0] ea;
        wr_n = 0; rd_n = 0; ld_n = 0; addr_bad = 0; data_bad = 0; busy_bad = 0;
        if (!v.is_store) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                @(negedge Clk1);
                pl_en = 1'b1;
                pl_addr = v.base + 16'(i) * v.stride;
                pl_data = v.pat + 16'(i) * v.pstep;
            end
            @(negedge Clk1);
            pl_en = 1'b0;
        end
        vrd_base = v.pat;
        @(negedge Clk1);
        bus.Start = 1'b1;
        bus.IsStore = v.is_store;
        bus.BaseAddr = v.base;
`ifdef VMS_STRIDE_EN
        bus.Stride = v.stride;
`endif
        @(negedge Clk1);
        bus.Start = 1'b0;
        cyc = 1;
        while (bus.Done !== 1'b1 && cyc < 200) begin
            if (bus.Busy !== 1'b1) busy_bad++;
            if (bus.WR === 1'b1) begin
                ea = v.base + 16'(wr_n) * v.stride;
                if (bus.Addr !== ea) addr_bad++;
                if (bus.DataOut !== v.pat + 16'(wr_n)) data_bad++;
                wr_n++;
            end
            if (bus.RD === 1'b1) begin
                ea = v.base + 16'(rd_n) * v.stride;
                if (bus.Addr !== ea) addr_bad++;
                rd_n++;
            end
            if (bus.VecWrEn === 1'b1) begin
                if (32'(bus.ElemIdx) != ld_n) data_bad++;
                if (bus.VecWrData !== v.pat + 16'(ld_n) * v.pstep) data_bad++;
                ld_n++;
            end
            bus.Start = (v.poke && cyc == 5);
            @(negedge Clk1);
            cyc++;
        end
        bus.Start = 1'b0;
        chk("latency", 64'(cyc), 64'(v.lat));
        chk("busy_at_done", 64'(bus.Busy), 64'd0);
        chk("busy_during", 64'(busy_bad), 64'd0);
        chk("wr_count", 64'(wr_n), v.is_store ? 64'd16 : 64'd0);
        chk("rd_count", 64'(rd_n), v.is_store ? 64'd0 : 64'd16);
        chk("ret_count", 64'(ld_n), v.is_store ? 64'd0 : 64'd16);
        chk("addr_seq", 64'(addr_bad), 64'd0);
        chk("data_seq", 64'(data_bad), 64'd0);
        // Start on the Done cycle must be dropped.
        act = 0;
        if (v.poke) bus.Start = 1'b1;
        @(negedge Clk1);
        bus.Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.Busy !== 1'b0 || bus.RD !== 1'b0 || bus.WR !== 1'b0) act++;
            @(negedge Clk1);
        end
        chk("idle_after_done", 64'(act), 64'd0);
        chk("addr_hold", 64'(bus.Addr), 64'(16'(v.base + 16'd15 * v.stride)));
        mis = 0;
        if (v.is_store) begin
            exp_mem.delete();
            for (int i = 0; i < VEC_LEN; i++) exp_mem[16'(v.base + 16'(i) * v.stride)] = v.pat + 16'(i);
            foreach (exp_mem[a]) if (mem[a] !== exp_mem[a]) mis++;
            chk("dram_dump", 64'(mis), 64'd0);
        end else begin
            for (int i = 0; i < VEC_LEN; i++) if (vreg[i] !== v.pat + 16'(i) * v.pstep) mis++;
            chk("vreg_dump", 64'(mis), 64'd0);
        end
    endtask

    initial begin
        int d0, waited;
        Reset_n = 1'b0;
        bus.Start = 1'b0;
        bus.IsStore = 1'b0;
        bus.BaseAddr = '0;
`ifdef VMS_STRIDE_EN
        bus.Stride = '0;
`endif
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        vrd_base = '0;
        repeat (3) @(negedge Clk1);
        chk("reset_outs", outs_vec(), 64'd0);
        Reset_n = 1'b1;

        tab[0] = '{1'b0, 16'h0040, 16'd1, 16'hA000, 16'd1, 1'b0, 18};
        tab[1] = '{1'b1, 16'h0100, 16'd1, 16'h5500, 16'd1, 1'b1, 17};
        tab[2] = '{1'b0, 16'hFFFC, 16'd1, 16'hC000, 16'd1, 1'b1, 18};
        tab[3] = '{1'b1, 16'hFFFC, 16'd1, 16'h6600, 16'd1, 1'b0, 17};
        ntab = 4;
`ifdef VMS_STRIDE_EN
        tab[4] = '{1'b0, 16'h0000, 16'd4, 16'h7000, 16'd1, 1'b0, 18};
        tab[5] = '{1'b1, 16'h0000, 16'd4, 16'h8800, 16'd1, 1'b0, 17};
        tab[6] = '{1'b0, 16'h0000, 16'd0, 16'hBEEF, 16'd0, 1'b0, 18};
        ntab = 7;
`endif
        for (int t = 0; t < ntab; t++) run_vec(tab[t]);

        // Reset in the middle of a load, at element 5.
        @(negedge Clk1);
        bus.Start = 1'b1;
        bus.IsStore = 1'b0;
        bus.BaseAddr = 16'h0040;
`ifdef VMS_STRIDE_EN
        bus.Stride = 16'd1;
`endif
        @(negedge Clk1);
        bus.Start = 1'b0;
        waited = 0;
        while (!(bus.RD === 1'b1 && bus.Addr === 16'h0045) && waited < 50) begin
            @(negedge Clk1);
            waited++;
        end
        chk("reach_elem5", 64'(waited < 50), 64'd1);
        d0 = done_cnt;
        #2 Reset_n = 1'b0;
        #1 chk("async_reset_outs", outs_vec(), 64'd0);
        @(negedge Clk1);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clk1);
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
        chk("idle_after_reset", 64'(bus.Busy), 64'd0);
        run_vec(tab[0]);

        chk("rd_wr_overlap", 64'(both_cnt), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
